clk_rst_monitor: RTL
====================

# clk_rst_monitor

Receive-side checker for the clock/reset agent's outputs. It oversamples one agent-generated clock and the complementary reset pair (SYS_RST / SYS_RST_N) in the system clock domain, measures the clock period in sys_clk cycles, and declares lock after a run of in-range periods. It flags period violations, stopped clocks, reset-pair mismatch and short reset pulses. It sits at the DUT boundary beside the agent interface and is also synthesizable for on-chip clock supervision.

## Interface
- PERIOD_MIN, 3: minimum legal period, sys_clk cycles
- PERIOD_MAX, 5: maximum legal period, sys_clk cycles
- CNT_W, 8: period counter width; all-ones is the stopped-clock timeout
- LOCK_CNT, 4: consecutive in-range periods required for lock
- RST_MIN_CYC, 16: minimum legal reset assertion, sys_clk cycles
- sys_clk  in  1  system clock, sole clock
- sys_rst_n  in  1  asynchronous, active-low reset
- enable_i  in  1  monitor enable; low forces IDLE
- clr_i  in  1  clears the sticky error flags
- mon_clk_i  in  1  monitored clock, asynchronous, sampled as data
- mon_rst_i  in  1  monitored SYS_RST, active-high
- mon_rst_n_i  in  1  monitored SYS_RST_N, active-low
- period_o  out  CNT_W  last measured period
- period_vld_o  out  1  one-cycle strobe when period_o updates
- locked_o  out  1  high in LOCKED state
- err_period_o  out  1  sticky: out-of-range period or stop while locked
- err_rst_pair_o  out  1  sticky: reset pair not complementary
- err_rst_width_o  out  1  sticky: reset pulse shorter than RST_MIN_CYC

## Operation
- Each mon_* input goes through a 2-flop synchronizer. Rising edge = synced high and delayed synced low.
- Period counter: increments every cycle and saturates at 2^CNT_W-1. It reloads to 1 on each rising edge.
- On an edge in MEAS or LOCKED: period_o <= counter value, and period_vld_o pulses.
- FSM states: IDLE, ACQ, MEAS, LOCKED.
  - IDLE -> ACQ when enable_i is high.
  - ACQ -> MEAS on the first rising edge. This edge only starts the count; no measurement and no strobe.
  - MEAS: an in-range period (PERIOD_MIN ≤ p ≤ PERIOD_MAX, inclusive) increments the good count. An out-of-range period zeroes the good count and raises no error. The good count reaching LOCK_CNT -> LOCKED.
  - LOCKED: an out-of-range period sets err_period_o and returns to MEAS with the good count zeroed.
  - Counter saturation (stopped clock): from MEAS, go to ACQ; from LOCKED, set err_period_o and go to ACQ.
  - enable_i low: any state -> IDLE. The counter and good count clear; period_o holds its value.
- Reset pair check: synced mon_rst equal to synced mon_rst_n for 2 consecutive cycles sets err_rst_pair_o. A 1-cycle skew is tolerated.
- Reset width check: a width counter runs while synced mon_rst is high and saturates at RST_MIN_CYC. On the falling edge of synced mon_rst, a count below RST_MIN_CYC sets err_rst_width_o. A reset already high when sys_rst_n releases is measured from that release.
- Reset checks run regardless of FSM state and enable_i.
- clr_i clears all sticky flags. If a new error occurs in the same cycle as clr_i, the error wins and the flag stays set.

## Timing
- Reset values: period_o = 0, and period_vld_o, locked_o and all err_* = 0. The FSM resets to IDLE; all counters and synchronizers reset to 0.
- A mon_clk_i rise first sampled at sys_clk edge k gives period_vld_o and the new period_o valid after edge k+3. locked_o and err_period_o update at the same edge.
- Reset-pair error: flag visible 2 cycles after synchronizer output, 4 sys_clk edges after the mismatch is first sampled.
- Rising-edge detection is reliable only for mon_clk_i high and low phases of at least one sys_clk period each. Narrower pulses may be missed; this is a usage constraint, not checked.
- Asserting sys_rst_n mid-operation clears all state immediately. Lock must be reacquired from ACQ.

## Structure
- The shared package ClkAgentUserPkg gets:
  - the state typedef mon_state_t {IDLE, ACQ, MEAS, LOCKED}
  - default constants for PERIOD_MIN, PERIOD_MAX and RST_MIN_CYC.
- One sub-module, clk_rst_sync2: a parameterized-width 2-flop synchronizer with async active-low reset, instantiated once for 3 bits.

## Test plan
- Lock on nominal clock: sys_clk 100 MHz, mon_clk_i 25 MHz, defaults -> period_o = 4 on every strobe. locked_o rises with the 4th strobe (the 5th mon rising edge); no errors.
- Out-of-range while locked: after lock, one period of 7 cycles -> period_o = 7, err_period_o = 1, locked_o = 0. Relock after 4 more good periods; the err flag stays set until clr_i.
- Stopped clock: after lock, hold mon_clk_i low -> err_period_o sets after counter saturation (255 cycles since last edge). FSM goes to ACQ, and the next edge produces no strobe.
- Reset pair: SYS_RST_N lags SYS_RST by 1 cycle -> no error. A 2-cycle lag sets err_rst_pair_o. clr_i pulse clears it.
- Reset width: mon_rst_i high for 10 cycles with RST_MIN_CYC = 16 -> err_rst_width_o = 1. A 16-cycle pulse -> no error.
- Async reset mid-lock: assert sys_rst_n low while locked -> all outputs 0 immediately. After release, lock is reacquired in 5 mon edges.

Source files
------------

// File: rtl/clk_rst_monitor_pkg.sv
// ClkAgentUserPkg: types and default constants shared by the clock/reset
// receive-side monitor and its users.
//   mon_state_t      - monitor FSM state encoding
//   DEF_PERIOD_MIN   - default minimum legal clock period (sys_clk cycles)
//   DEF_PERIOD_MAX   - default maximum legal clock period (sys_clk cycles)
//   DEF_RST_MIN_CYC  - default minimum legal reset assertion (sys_clk cycles)
package ClkAgentUserPkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    MEAS   = 2'd2,
    LOCKED = 2'd3
  } mon_state_t;

  localparam int DEF_PERIOD_MIN  = 3;
  localparam int DEF_PERIOD_MAX  = 5;
  localparam int DEF_RST_MIN_CYC = 16;

endpackage

// File: rtl/clk_rst_sync2.sv
// Two-flop synchronizer, parameterized width, async active-low reset.
//   sys_clk   - destination clock
//   sys_rst_n - async active-low reset, flops clear to 0
//   d_i       - asynchronous inputs
//   q_o       - synchronized outputs (2 cycles of latency)
module clk_rst_sync2 #(
  parameter int W = 1
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q, sync_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/clk_rst_monitor.sv
// Receive-side clock/reset monitor. Oversamples a monitored clock and a
// complementary reset pair in the sys_clk domain, measures the clock period,
// declares lock after LOCK_CNT consecutive in-range periods and raises sticky
// flags for period violations, stopped clocks, reset-pair mismatch and short
// reset pulses.
//   sys_clk, sys_rst_n          - system clock, async active-low reset
//   enable_i                    - monitor enable (low forces IDLE)
//   clr_i                       - clears sticky error flags (new error wins)
//   mon_clk_i                   - monitored clock, sampled as data
//   mon_rst_i, mon_rst_n_i      - monitored SYS_RST / SYS_RST_N
//   period_o, period_vld_o      - last measured period and its update strobe
//   locked_o                    - FSM in LOCKED
//   err_period_o                - sticky out-of-range/stop while locked
//   err_rst_pair_o              - sticky reset pair not complementary
//   err_rst_width_o             - sticky reset pulse too short
module clk_rst_monitor
  import ClkAgentUserPkg::*;
#(
  parameter int PERIOD_MIN  = DEF_PERIOD_MIN,
  parameter int PERIOD_MAX  = DEF_PERIOD_MAX,
  parameter int CNT_W       = 8,
  parameter int LOCK_CNT    = 4,
  parameter int RST_MIN_CYC = DEF_RST_MIN_CYC
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             enable_i,
  input  logic             clr_i,
  input  logic             mon_clk_i,
  input  logic             mon_rst_i,
  input  logic             mon_rst_n_i,
  output logic [CNT_W-1:0] period_o,
  output logic             period_vld_o,
  output logic             locked_o,
  output logic             err_period_o,
  output logic             err_rst_pair_o,
  output logic             err_rst_width_o
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(RST_MIN_CYC + 1);
  localparam logic [CNT_W-1:0] PMIN    = CNT_W'(PERIOD_MIN);
  localparam logic [CNT_W-1:0] PMAX    = CNT_W'(PERIOD_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [GW-1:0]    LOCK_V  = GW'(LOCK_CNT);
  localparam logic [WW-1:0]    WMAX    = WW'(RST_MIN_CYC);

  logic [2:0] sync_w;
  logic       clk_s, rst_s, rstn_s;

  clk_rst_sync2 #(.W(3)) u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .d_i       ({mon_rst_n_i, mon_rst_i, mon_clk_i}),
    .q_o       (sync_w)
  );

  assign clk_s  = sync_w[0];
  assign rst_s  = sync_w[1];
  assign rstn_s = sync_w[2];

  // ---------------- clock period / lock ----------------
  mon_state_t       st_q, st_d;
  logic             clk_d_q, rise_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
  logic [GW-1:0]    good_q, good_d;
  logic             vld_q, vld_d, err_per_q, per_err, in_range;

  assign in_range = (cnt_q >= PMIN) && (cnt_q <= PMAX);

  always_comb begin
    st_d     = st_q;
    cnt_d    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
    good_d   = good_q;
    period_d = period_q;
    vld_d    = 1'b0;
    per_err  = 1'b0;
    if (!enable_i) begin
      st_d   = IDLE;
      cnt_d  = '0;
      good_d = '0;
    end else begin
      case (st_q)
        IDLE: st_d = ACQ;
        ACQ: if (rise_q) begin
          // first edge only starts the count
          st_d  = MEAS;
          cnt_d = CNT_W'(1);
        end
        MEAS, LOCKED: begin
          if (rise_q) begin
            vld_d    = 1'b1;
            period_d = cnt_q;
            cnt_d    = CNT_W'(1);
            if (!in_range) begin
              good_d = '0;
              if (st_q == LOCKED) begin
                per_err = 1'b1;
                st_d    = MEAS;
              end
            end else if (st_q == MEAS) begin
              good_d = good_q + 1'b1;
              if (good_q + 1'b1 == LOCK_V) st_d = LOCKED;
            end
          end else if (cnt_q == CNT_SAT) begin
            // monitored clock stopped
            st_d    = ACQ;
            good_d  = '0;
            per_err = (st_q == LOCKED);
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  // rise_q adds one stage after edge detect so outputs land at edge k+3
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      st_q      <= IDLE;
      clk_d_q   <= 1'b0;
      rise_q    <= 1'b0;
      cnt_q     <= '0;
      good_q    <= '0;
      period_q  <= '0;
      vld_q     <= 1'b0;
      err_per_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      clk_d_q   <= clk_s;
      rise_q    <= clk_s & ~clk_d_q;
      cnt_q     <= cnt_d;
      good_q    <= good_d;
      period_q  <= period_d;
      vld_q     <= vld_d;
      err_per_q <= (err_per_q & ~clr_i) | per_err;
    end
  end

  // ---------------- reset pair / width ----------------
  // vld_pipe masks the pair check until the synchronizers hold real samples;
  // both synced bits come out of reset at 0, which would look like a mismatch.
  logic [1:0]    vld_pipe;
  logic          eq_q, eq_qq, rst_d_q, pair_err_q, width_err_q;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          rst_fall;

  assign rst_fall = rst_d_q & ~rst_s;
  assign wcnt_d   = !rst_s ? '0 : (wcnt_q == WMAX) ? wcnt_q : wcnt_q + 1'b1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_pipe    <= '0;
      eq_q        <= 1'b0;
      eq_qq       <= 1'b0;
      rst_d_q     <= 1'b0;
      wcnt_q      <= '0;
      pair_err_q  <= 1'b0;
      width_err_q <= 1'b0;
    end else begin
      vld_pipe    <= {vld_pipe[0], 1'b1};
      eq_q        <= vld_pipe[1] & (rst_s == rstn_s);
      eq_qq       <= eq_q;
      rst_d_q     <= rst_s;
      wcnt_q      <= wcnt_d;
      pair_err_q  <= (pair_err_q & ~clr_i) | (eq_q & eq_qq);
      width_err_q <= (width_err_q & ~clr_i) | (rst_fall & (wcnt_q < WMAX));
    end
  end

  assign period_o        = period_q;
  assign period_vld_o    = vld_q;
  assign locked_o        = (st_q == LOCKED);
  assign err_period_o    = err_per_q;
  assign err_rst_pair_o  = pair_err_q;
  assign err_rst_width_o = width_err_q;

endmodule
